pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised backend pipeline register chain: STAGES stages, each carrying a valid bit, an opaque control word and NOPND operand values.
- Tracks, per operand, the relative stage distance to its producer and re-targets forwarding automatically across stalls. The value is captured when the producer retires.
- Successor to the fixed ex/m1/m2/wb chain with hand-coded forwarding one-hots; generalised in stage count, pipe count and operand count.
- Sits between the issue stage and the execute/memory units of each backend pipe.

Parameters:
- STAGES, 4, number of pipeline stages (stage 0 = first execute stage, STAGES-1 = writeback), >=2
- PIPES, 2, number of parallel pipes supplying forwarding sources, >=1
- NOPND, 2, source operands per instruction
- DATA_W, 32, operand/result width
- CTRL_W, 64, opaque control payload width
- DIST_W, $clog2(STAGES), width of producer-distance field
- PSEL_W, max(1,$clog2(PIPES)), width of producer-pipe select

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_i  in  1  valid instruction offered to stage 0
- issue_ctrl_i  in  CTRL_W  control payload of issued instruction
- issue_opnd_i  in  NOPND*DATA_W  register-file operand values
- issue_dist_i  in  NOPND*DIST_W  producer distance per operand (0 = no forwarding, value from issue_opnd_i)
- issue_psel_i  in  NOPND*PSEL_W  producer pipe per operand
- stall_i  in  STAGES  per-stage stall request (bit STAGES-1 ignored)
- clr_i  in  STAGES  clr_i[s]: content leaving stage s is killed (bubble enters s+1); bit STAGES-1 kills writeback
- flush_i  in  1  kill all stages
- fwd_src_i  in  PIPES*STAGES*DATA_W  result of pipe p at stage s (index [p][s]; s=0 unused)
- hold_o  out  STAGES  effective per-stage hold
- stage_valid_o  out  STAGES  stage holds a live instruction
- stage_ctrl_o  out  STAGES*CTRL_W  control payload per stage
- stage_opnd_o  out  STAGES*NOPND*DATA_W  forwarded operand values per stage (combinational)

Behaviour:
- Reset (rst=1 at edge): all valid=0, ctrl=0, dist=0, psel=0, operand data=0. hold_o reflects current stall_i even during reset.
- Effective hold: hold[STAGES-1]=0; hold[s]=stall_i[s] | hold[s+1] for s<STAGES-1. A stage advances when hold[s]=0.
- Stage 0 load when not held: issue_i=1 loads payload/operands/dist/psel; issue_i=0 loads bubble (valid=0, dist=0).
- Stage s+1 load when not held: if hold[s]=1 -> bubble; else if clr_i[s] -> bubble; else copy stage s with updated dist and data.
- Writeback stage (STAGES-1) valid is cleared next cycle when clr_i[STAGES-1]=1, else it takes stage STAGES-2 or a bubble.
- Held stage keeps ctrl/valid; clr_i on a held stage is ignored.
- flush_i: all valid=0, all dist=0 next cycle; overrides issue, stall and clr; rst overrides flush.
- Operand mux: stage_opnd_o[s][k] = fwd_src_i[psel][s+dist] when dist!=0, else the stored data.
- Operand data register always latches the muxed value, whether it moves or holds, so it is current once resolved.
- Distance update for an operand of stage s with dist d>0:
  - Producer at stage q=s+d, producer moves iff hold[q]=0 (q=STAGES-1 always moves and retires).
  - Consumer new stage c'=s+(hold[s]?0:1); producer new stage q'=q+(hold[q]?0:1).
  - If q'>STAGES-1: dist'=0 and data' = the current muxed value (capture at retirement).
  - Else dist'=q'-c'.
  - Since hold is monotone upstream, q' never falls below c'.
- Illegal: issue_dist_i >= STAGES-0 must not occur. A bench assertion checks s+dist <= STAGES-1 for every valid stage; behaviour when violated is undefined.
- Latency: an instruction accepted at edge k occupies stage s after edge k+s when there are no stalls.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> stage_valid_o=0, all dist 0, stage_opnd_o for dist-0 operands reads 0.
- Straight flow: issue ctrl=0x5A at edge 0, stall_i=0 -> stage_ctrl_o[s]=0x5A with valid exactly after edge s, s=0..3; valid clears afterwards.
- Forward, no stall: stage 0 operand 0 dist=1 psel=1, fwd_src_i[1][1]=0xDEAD -> stage_opnd_o[0][0]=0xDEAD. Next cycle dist stays 1 and stage_opnd_o[1][0] tracks fwd_src_i[1][2].
- Consumer stall: stall_i=0001, stage 0 operand dist=1 -> dist becomes 2 then 3. On the next edge the producer leaves stage 3 and value 0x1234 on fwd_src_i[p][3] is captured: dist=0, stage_opnd_o[0]=0x1234 while still held.
- Stall at STAGES-2: stall_i=0100 -> hold_o=0111, stage 3 valid=0 next cycle, stages 0-2 unchanged.
- Clear and flush: clr_i=0010 with no stall -> stage 2 valid=0 next cycle and stage 1 refilled from stage 0. flush_i=1 together with issue_i=1 -> all valid=0 next cycle.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: backend pipeline register chain with per-operand producer
// tracking. Each operand records how many stages ahead its producer sits. The
// distance is re-targeted every cycle as stalls split consumer and producer.
// The value is captured when the producer leaves the writeback stage.
module pipe_stage_chain #(
  parameter int STAGES = 4,
  parameter int PIPES  = 2,
  parameter int NOPND  = 2,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 64,
  parameter int DIST_W = (STAGES > 1) ? $clog2(STAGES) : 1,
  parameter int PSEL_W = (PIPES > 1) ? $clog2(PIPES) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             issue_i,
  input  logic [CTRL_W-1:0]                issue_ctrl_i,
  input  logic [NOPND*DATA_W-1:0]          issue_opnd_i,
  input  logic [NOPND*DIST_W-1:0]          issue_dist_i,
  input  logic [NOPND*PSEL_W-1:0]          issue_psel_i,
  input  logic [STAGES-1:0]                stall_i,
  input  logic [STAGES-1:0]                clr_i,
  input  logic                             flush_i,
  input  logic [PIPES*STAGES*DATA_W-1:0]   fwd_src_i,
  output logic [STAGES-1:0]                hold_o,
  output logic [STAGES-1:0]                stage_valid_o,
  output logic [STAGES*CTRL_W-1:0]         stage_ctrl_o,
  output logic [STAGES*NOPND*DATA_W-1:0]   stage_opnd_o
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q [STAGES];
  logic [CTRL_W-1:0] ctrl_d [STAGES];
  logic [DIST_W-1:0] dist_q [STAGES][NOPND];
  logic [DIST_W-1:0] dist_d [STAGES][NOPND];
  logic [PSEL_W-1:0] psel_q [STAGES][NOPND];
  logic [PSEL_W-1:0] psel_d [STAGES][NOPND];
  logic [DATA_W-1:0] data_q [STAGES][NOPND];
  logic [DATA_W-1:0] data_d [STAGES][NOPND];

  logic [STAGES-1:0] hold;
  logic [DATA_W-1:0] mux_val  [STAGES][NOPND];
  logic [DIST_W-1:0] upd_dist [STAGES][NOPND];

  // Hold propagates upstream from any stalled stage; writeback never holds.
  always_comb begin
    logic h;
    h    = 1'b0;
    hold = '0;
    for (int s = STAGES-1; s >= 0; s--) begin
      if (s < STAGES-1) h = h | stall_i[s];
      hold[s] = h;
    end
  end

  // Operand forwarding mux and next distance as seen from each stage.
  always_comb begin
    int q, qn, cn, p;
    q  = 0;
    qn = 0;
    cn = 0;
    p  = 0;
    for (int s = 0; s < STAGES; s++) begin
      for (int k = 0; k < NOPND; k++) begin
        mux_val[s][k]  = data_q[s][k];
        upd_dist[s][k] = '0;
        q = s + int'(dist_q[s][k]);
        p = int'(psel_q[s][k]);
        if (dist_q[s][k] != '0 && q <= STAGES-1 && p < PIPES) begin
          mux_val[s][k] = fwd_src_i[(p*STAGES + q)*DATA_W +: DATA_W];
          qn = q + (hold[q] ? 0 : 1);
          cn = s + (hold[s] ? 0 : 1);
          // A producer stepping past writeback retires; its value is captured.
          if (qn <= STAGES-1) upd_dist[s][k] = DIST_W'(qn - cn);
        end
      end
    end
  end

  // Next-state selection: hold, advance, bubble insertion, clear and flush.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      valid_d[s] = valid_q[s];
      ctrl_d[s]  = ctrl_q[s];
      for (int k = 0; k < NOPND; k++) begin
        dist_d[s][k] = upd_dist[s][k];
        psel_d[s][k] = psel_q[s][k];
        data_d[s][k] = mux_val[s][k];
      end
    end
    if (!hold[0]) begin
      valid_d[0] = issue_i;
      ctrl_d[0]  = issue_ctrl_i;
      for (int k = 0; k < NOPND; k++) begin
        dist_d[0][k] = issue_i ? issue_dist_i[k*DIST_W +: DIST_W] : '0;
        psel_d[0][k] = issue_psel_i[k*PSEL_W +: PSEL_W];
        data_d[0][k] = issue_opnd_i[k*DATA_W +: DATA_W];
      end
    end
    for (int s = 1; s < STAGES; s++) begin
      if (!hold[s]) begin
        if (hold[s-1] || clr_i[s-1] || (s == STAGES-1 && clr_i[STAGES-1])) begin
          valid_d[s] = 1'b0;
          for (int k = 0; k < NOPND; k++) dist_d[s][k] = '0;
        end else begin
          valid_d[s] = valid_q[s-1];
          ctrl_d[s]  = ctrl_q[s-1];
          for (int k = 0; k < NOPND; k++) begin
            dist_d[s][k] = upd_dist[s-1][k];
            psel_d[s][k] = psel_q[s-1][k];
            data_d[s][k] = mux_val[s-1][k];
          end
        end
      end
    end
    if (flush_i) begin
      valid_d = '0;
      for (int s = 0; s < STAGES; s++)
        for (int k = 0; k < NOPND; k++) dist_d[s][k] = '0;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        ctrl_q[s] <= '0;
        for (int k = 0; k < NOPND; k++) begin
          dist_q[s][k] <= '0;
          psel_q[s][k] <= '0;
          data_q[s][k] <= '0;
        end
      end
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < STAGES; s++) begin
        ctrl_q[s] <= ctrl_d[s];
        for (int k = 0; k < NOPND; k++) begin
          dist_q[s][k] <= dist_d[s][k];
          psel_q[s][k] <= psel_d[s][k];
          data_q[s][k] <= data_d[s][k];
        end
      end
    end
  end

  // Flatten stage state onto the output buses.
  always_comb begin
    hold_o        = hold;
    stage_valid_o = valid_q;
    stage_ctrl_o  = '0;
    stage_opnd_o  = '0;
    for (int s = 0; s < STAGES; s++) begin
      stage_ctrl_o[s*CTRL_W +: CTRL_W] = ctrl_q[s];
      for (int k = 0; k < NOPND; k++)
        stage_opnd_o[(s*NOPND + k)*DATA_W +: DATA_W] = mux_val[s][k];
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain: directed scenarios plus randomized traffic,
// checked against a model that tracks each producer's absolute stage position.
module tb_pipe_stage_chain;
  localparam int S   = 4;
  localparam int P   = 2;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int CW  = 64;
  localparam int DIW = 2;
  localparam int PSW = 1;
  localparam int MAXID = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, issue_i, flush_i;
  logic [CW-1:0]        issue_ctrl_i;
  logic [S-1:0]         stall_i, clr_i;
  logic [DW-1:0]        iss_opnd [N];
  int                   iss_dist [N];
  int                   iss_psel [N];
  logic [DW-1:0]        fwd_tb [P][S];
  logic [N*DW-1:0]      issue_opnd_i;
  logic [N*DIW-1:0]     issue_dist_i;
  logic [N*PSW-1:0]     issue_psel_i;
  logic [P*S*DW-1:0]    fwd_src_i;
  logic [S-1:0]         hold_o, stage_valid_o;
  logic [S*CW-1:0]      stage_ctrl_o;
  logic [S*N*DW-1:0]    stage_opnd_o;

  pipe_stage_chain dut (
    .clk(clk), .rst(rst), .issue_i(issue_i), .issue_ctrl_i(issue_ctrl_i),
    .issue_opnd_i(issue_opnd_i), .issue_dist_i(issue_dist_i), .issue_psel_i(issue_psel_i),
    .stall_i(stall_i), .clr_i(clr_i), .flush_i(flush_i), .fwd_src_i(fwd_src_i),
    .hold_o(hold_o), .stage_valid_o(stage_valid_o), .stage_ctrl_o(stage_ctrl_o),
    .stage_opnd_o(stage_opnd_o)
  );

  always_comb begin
    issue_opnd_i = '0;
    issue_dist_i = '0;
    issue_psel_i = '0;
    fwd_src_i    = '0;
    for (int k = 0; k < N; k++) begin
      issue_opnd_i[k*DW +: DW]   = iss_opnd[k];
      issue_dist_i[k*DIW +: DIW] = DIW'(iss_dist[k]);
      issue_psel_i[k*PSW +: PSW] = PSW'(iss_psel[k]);
    end
    for (int p = 0; p < P; p++)
      for (int s = 0; s < S; s++) fwd_src_i[(p*S + s)*DW +: DW] = fwd_tb[p][s];
  end

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int cur_id = 0;
  int sb_q[$];
  bit killed [MAXID];
  logic [CW-1:0] exp_ctrl [MAXID];

  // Model: per slot, each operand is either resolved (value known) or waits on
  // a producer at an absolute stage m_pst in pipe m_psel.
  bit            m_v    [S];
  logic [CW-1:0] m_ctrl [S];
  int            m_id   [S];
  bit            m_res  [S][N];
  logic [DW-1:0] m_val  [S][N];
  int            m_pst  [S][N];
  int            m_psel [S][N];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [S-1:0] hold_of(logic [S-1:0] st);
    logic [S-1:0] h = '0;
    for (int s = S-2; s >= 0; s--) h[s] = st[s] | h[s+1];
    return h;
  endfunction

  function automatic logic [DW-1:0] exp_op(int s, int k);
    return m_res[s][k] ? m_val[s][k] : fwd_tb[m_psel[s][k]][m_pst[s][k]];
  endfunction

  function automatic logic [DW-1:0] dut_op(int s, int k);
    return stage_opnd_o[(s*N + k)*DW +: DW];
  endfunction

  task automatic model_step();
    logic [S-1:0] h;
    bit nv[S]; logic [CW-1:0] nc[S]; int nid[S];
    bit nr[S][N]; logic [DW-1:0] nval[S][N]; int np[S][N]; int nps[S][N];
    bit ov[S]; int oid[S];
    for (int s = 0; s < S; s++) begin ov[s] = m_v[s]; oid[s] = m_id[s]; end
    h = hold_of(stall_i);
    if (rst) begin
      for (int s = 0; s < S; s++) begin
        m_v[s] = 1'b0; m_ctrl[s] = '0; m_id[s] = -1;
        for (int k = 0; k < N; k++) begin
          m_res[s][k] = 1'b1; m_val[s][k] = '0; m_pst[s][k] = 0; m_psel[s][k] = 0;
        end
      end
    end else begin
      for (int s = 0; s < S; s++)
        for (int k = 0; k < N; k++)
          if (!m_res[s][k] && !h[m_pst[s][k]]) begin
            if (m_pst[s][k] == S-1) begin
              m_res[s][k] = 1'b1;
              m_val[s][k] = fwd_tb[m_psel[s][k]][S-1];
            end else m_pst[s][k] = m_pst[s][k] + 1;
          end
      for (int s = 0; s < S; s++) begin
        nv[s] = m_v[s]; nc[s] = m_ctrl[s]; nid[s] = m_id[s];
        for (int k = 0; k < N; k++) begin
          nr[s][k] = m_res[s][k]; nval[s][k] = m_val[s][k];
          np[s][k] = m_pst[s][k]; nps[s][k] = m_psel[s][k];
        end
      end
      if (!h[0]) begin
        nv[0] = issue_i; nc[0] = issue_ctrl_i; nid[0] = cur_id;
        for (int k = 0; k < N; k++) begin
          nr[0][k] = (iss_dist[k] == 0); nval[0][k] = iss_opnd[k];
          np[0][k] = iss_dist[k]; nps[0][k] = iss_psel[k];
        end
        if (issue_i && !flush_i) begin
          sb_q.push_back(cur_id);
          exp_ctrl[cur_id] = issue_ctrl_i;
        end
      end
      for (int s = 1; s < S; s++)
        if (!h[s]) begin
          if (h[s-1] || clr_i[s-1] || (s == S-1 && clr_i[S-1])) begin
            nv[s] = 1'b0;
            for (int k = 0; k < N; k++) nr[s][k] = 1'b1;
          end else begin
            nv[s] = m_v[s-1]; nc[s] = m_ctrl[s-1]; nid[s] = m_id[s-1];
            for (int k = 0; k < N; k++) begin
              nr[s][k] = m_res[s-1][k]; nval[s][k] = m_val[s-1][k];
              np[s][k] = m_pst[s-1][k]; nps[s][k] = m_psel[s-1][k];
            end
          end
        end
      if (flush_i)
        for (int s = 0; s < S; s++) begin
          nv[s] = 1'b0;
          for (int k = 0; k < N; k++) nr[s][k] = 1'b1;
        end
      for (int s = 0; s < S; s++) begin
        m_v[s] = nv[s]; m_ctrl[s] = nc[s]; m_id[s] = nid[s];
        for (int k = 0; k < N; k++) begin
          m_res[s][k] = nr[s][k]; m_val[s][k] = nval[s][k];
          m_pst[s][k] = np[s][k]; m_psel[s][k] = nps[s][k];
        end
      end
    end
    for (int s = 0; s < S-1; s++)
      if (ov[s]) begin
        bit found = 1'b0;
        for (int t = 0; t < S; t++) if (m_v[t] && m_id[t] == oid[s]) found = 1'b1;
        if (!found && oid[s] >= 0) killed[oid[s]] = 1'b1;
      end
    for (int s = 0; s < S; s++)
      for (int k = 0; k < N; k++)
        if (m_v[s] && !m_res[s][k])
          assert (m_pst[s][k] > s && m_pst[s][k] <= S-1)
            else $error("producer position out of range at stage %0d", s);
    cur_id++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    issue_i = 1'b0; stall_i = '0; clr_i = '0; flush_i = 1'b0;
    for (int k = 0; k < N; k++) begin iss_dist[k] = 0; iss_psel[k] = 0; iss_opnd[k] = $urandom; end
  endtask

  task automatic rnd_inputs();
    issue_i = ($urandom_range(0, 9) < 7);
    issue_ctrl_i = {$urandom, $urandom};
    for (int k = 0; k < N; k++) begin
      iss_opnd[k] = $urandom;
      iss_dist[k] = $urandom_range(0, S-1);
      iss_psel[k] = $urandom_range(0, P-1);
    end
    for (int s = 0; s < S; s++) begin
      stall_i[s] = ($urandom_range(0, 99) < 15);
      clr_i[s]   = ($urandom_range(0, 99) < 4);
    end
    flush_i = ($urandom_range(0, 59) == 0);
    for (int p = 0; p < P; p++)
      for (int s = 0; s < S; s++) fwd_tb[p][s] = $urandom;
  endtask

  // Monitor: per-cycle hold/valid/operand comparison and writeback scoreboard.
  always @(negedge clk) begin
    logic [S-1:0] ev;
    int id;
    if (mon_en) begin
      for (int s = 0; s < S; s++) ev[s] = m_v[s];
      chk("hold", 64'(hold_o), 64'(hold_of(stall_i)));
      chk("valid", 64'(stage_valid_o), 64'(ev));
      for (int s = 0; s < S-1; s++)
        if (m_v[s] && stage_valid_o[s]) begin
          chk("stage_ctrl", stage_ctrl_o[s*CW +: CW], m_ctrl[s]);
          for (int k = 0; k < N; k++) chk("stage_opnd", 64'(dut_op(s, k)), 64'(exp_op(s, k)));
        end
      if (stage_valid_o[S-1]) begin
        while (sb_q.size() > 0 && killed[sb_q[0]]) void'(sb_q.pop_front());
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL wb_unexpected actual=valid required=no_pending_instruction");
        end else begin
          id = sb_q.pop_front();
          chk("wb_ctrl", stage_ctrl_o[(S-1)*CW +: CW], exp_ctrl[id]);
          if (m_v[S-1])
            for (int k = 0; k < N; k++) chk("wb_opnd", 64'(dut_op(S-1, k)), 64'(exp_op(S-1, k)));
        end
      end
    end
  end

  initial begin
    int live;
    rst = 1'b1;
    quiet();
    issue_ctrl_i = '0;
    for (int p = 0; p < P; p++)
      for (int s = 0; s < S; s++) fwd_tb[p][s] = $urandom;
    for (int s = 0; s < S; s++) m_v[s] = 1'b0;

    // reset with random inputs for two cycles
    rnd_inputs();
    tick();
    mon_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      rnd_inputs();
      @(negedge clk);
      chk("rst_valid", 64'(stage_valid_o), 64'd0);
      chk("rst_opnd_zero", 64'(stage_opnd_o == '0), 64'd1);
      tick();
    end
    rst = 1'b0;
    quiet();
    tick();

    // straight flow
    issue_i = 1'b1; issue_ctrl_i = 64'h5A;
    tick();
    issue_i = 1'b0;
    for (int s = 0; s < S; s++) begin
      @(negedge clk);
      chk("flow_valid", 64'(stage_valid_o), 64'(1) << s);
      chk("flow_ctrl", stage_ctrl_o[s*CW +: CW], 64'h5A);
      tick();
    end
    @(negedge clk);
    chk("flow_empty", 64'(stage_valid_o), 64'd0);

    // forward without stall
    issue_i = 1'b1; issue_ctrl_i = 64'h77; iss_dist[0] = 1; iss_psel[0] = 1;
    tick();
    issue_i = 1'b0; iss_dist[0] = 0; iss_psel[0] = 0;
    fwd_tb[1][1] = 32'hDEAD;
    @(negedge clk);
    chk("fwd_s0", 64'(dut_op(0, 0)), 64'hDEAD);
    fwd_tb[1][2] = 32'hBEEF;
    tick();
    @(negedge clk);
    chk("fwd_s1", 64'(dut_op(1, 0)), 64'hBEEF);
    repeat (4) tick();

    // consumer stall, producer retires and value is captured
    issue_i = 1'b1; issue_ctrl_i = 64'h88; iss_dist[0] = 1; iss_psel[0] = 0;
    tick();
    issue_i = 1'b0; iss_dist[0] = 0; stall_i = 4'b0001;
    tick();
    tick();
    fwd_tb[0][3] = 32'h1234;
    tick();
    fwd_tb[0][3] = 32'h5555;
    @(negedge clk);
    chk("cap_value", 64'(dut_op(0, 0)), 64'h1234);
    chk("cap_held_valid", 64'(stage_valid_o[0]), 64'd1);
    tick();
    @(negedge clk);
    chk("cap_stays", 64'(dut_op(0, 0)), 64'h1234);
    stall_i = '0;
    repeat (4) tick();

    // stall at STAGES-2
    for (int i = 0; i < S; i++) begin
      issue_i = 1'b1; issue_ctrl_i = 64'hC0 + 64'(i);
      tick();
    end
    issue_i = 1'b0; stall_i = 4'b0100;
    @(negedge clk);
    chk("hold_0100", 64'(hold_o), 64'b0111);
    tick();
    @(negedge clk);
    chk("stall2_valid", 64'(stage_valid_o), 64'b0111);
    for (int s = 0; s < S-1; s++)
      chk("stall2_ctrl", stage_ctrl_o[s*CW +: CW], 64'hC0 + 64'(S-1-s));
    stall_i = '0;

    // clear on stage 1 content, then flush with issue
    for (int i = 0; i < S; i++) begin
      issue_i = 1'b1; issue_ctrl_i = 64'hD0 + 64'(i);
      tick();
    end
    issue_i = 1'b0; clr_i = 4'b0010;
    tick();
    clr_i = '0;
    @(negedge clk);
    chk("clr_valid", 64'(stage_valid_o), 64'b1010);
    chk("clr_refill", stage_ctrl_o[1*CW +: CW], 64'hD3);
    flush_i = 1'b1; issue_i = 1'b1; issue_ctrl_i = 64'hEE;
    tick();
    flush_i = 1'b0; issue_i = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(stage_valid_o), 64'd0);

    // randomized traffic
    repeat (3000) begin
      rnd_inputs();
      tick();
    end

    // drain and confirm every surviving instruction reached writeback
    quiet();
    repeat (8) tick();
    @(negedge clk);
    live = 0;
    foreach (sb_q[i]) if (!killed[sb_q[i]]) live++;
    chk("sb_drain", 64'(live), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
